// File: rtl/switch_input_ctrl.sv
// Debounced switch/button inputs with edge-triggered interrupts, exposed as a
// small Wishbone classic register block.

module switch_input_lane #(
    parameter int DEBOUNCE = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sw,
    output logic raw,
    output logic state,
    output logic rise,
    output logic fall
);
    localparam int              CW       = $clog2(DEBOUNCE + 1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE - 1);

    logic          meta;
    logic          state_d;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            raw  <= 1'b0;
        end else begin
            meta <= sw;
            raw  <= meta;
        end
    end

    // Counter only runs while the synchronised level disagrees with the debounced one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= 1'b0;
            cnt   <= '0;
        end else if (raw == state) begin
            cnt   <= '0;
        end else if (cnt == CNT_LAST) begin
            state <= ~state;
            cnt   <= '0;
        end else begin
            cnt   <= cnt + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_d <= 1'b0;
        else        state_d <= state;
    end

    assign rise = state & ~state_d;
    assign fall = ~state & state_d;
endmodule

module switch_input_ctrl #(
    parameter int WIDTH    = 16,
    parameter int DEBOUNCE = 1000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_sw,
    input  logic [4:0]       i_wb_adr,
    input  logic [31:0]      i_wb_dat,
    input  logic             i_wb_we,
    input  logic             i_wb_cyc,
    input  logic             i_wb_stb,
    output logic             o_wb_ack,
    output logic [31:0]      o_wb_rdt,
    output logic             o_irq
);
    localparam logic [2:0] REG_STATE   = 3'd0;
    localparam logic [2:0] REG_RAW     = 3'd1;
    localparam logic [2:0] REG_IE      = 3'd2;
    localparam logic [2:0] REG_RISE_EN = 3'd3;
    localparam logic [2:0] REG_FALL_EN = 3'd4;
    localparam logic [2:0] REG_PENDING = 3'd5;

    typedef struct packed {
        logic             we;
        logic [2:0]       sel;
        logic [WIDTH-1:0] mask;
    } wb_req_t;

    logic [WIDTH-1:0] raw, state, rise, fall;
    logic [WIDTH-1:0] ie, rise_en, fall_en, pending;
    logic [WIDTH-1:0] pend_set, pend_clr;
    logic [31:0]      rd_word;
    logic             wb_req_vld, wb_wr;
    wb_req_t          req;
    logic             unused_bits;

    generate
        for (genvar n = 0; n < WIDTH; n++) begin : g_lane
            switch_input_lane #(.DEBOUNCE(DEBOUNCE)) u_lane (
                .clk   (clk),
                .rst_n (rst_n),
                .sw    (i_sw[n]),
                .raw   (raw[n]),
                .state (state[n]),
                .rise  (rise[n]),
                .fall  (fall[n])
            );
        end
    endgenerate

    assign req         = '{we: i_wb_we, sel: i_wb_adr[4:2], mask: i_wb_dat[WIDTH-1:0]};
    assign unused_bits = &{1'b0, i_wb_adr[1:0], i_wb_dat};
    assign wb_req_vld  = i_wb_cyc & i_wb_stb & ~o_wb_ack;
    // Writes commit on the ack cycle, while the master still holds the request.
    assign wb_wr       = o_wb_ack & i_wb_cyc & i_wb_stb & req.we;

    always_comb begin
        rd_word = '0;
        case (req.sel)
            REG_STATE:   rd_word[WIDTH-1:0] = state;
            REG_RAW:     rd_word[WIDTH-1:0] = raw;
            REG_IE:      rd_word[WIDTH-1:0] = ie;
            REG_RISE_EN: rd_word[WIDTH-1:0] = rise_en;
            REG_FALL_EN: rd_word[WIDTH-1:0] = fall_en;
            REG_PENDING: rd_word[WIDTH-1:0] = pending;
            default:     rd_word = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_wb_ack <= 1'b0;
            o_wb_rdt <= '0;
        end else begin
            o_wb_ack <= wb_req_vld;
            o_wb_rdt <= wb_req_vld ? rd_word : 32'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ie      <= '0;
            rise_en <= '0;
            fall_en <= '0;
        end else if (wb_wr) begin
            case (req.sel)
                REG_IE:      ie      <= req.mask;
                REG_RISE_EN: rise_en <= req.mask;
                REG_FALL_EN: fall_en <= req.mask;
                default: ;
            endcase
        end
    end

    // A new event wins over a simultaneous write-one-to-clear of the same bit.
    assign pend_set = (rise & rise_en) | (fall & fall_en);
    assign pend_clr = (wb_wr && req.sel == REG_PENDING) ? req.mask : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pending <= '0;
        else        pending <= (pending & ~pend_clr) | pend_set;
    end

    assign o_irq = |(pending & ie);
endmodule

// File: tb/tb_switch_input_ctrl.sv
// Bench for switch_input_ctrl: directed scenarios plus random switch/bus
// traffic against a window-based behavioural model.

module tb_switch_input_ctrl;
    localparam int W = 4;
    localparam int D = 4;
    localparam logic [2:0] A_STATE = 3'd0, A_RAW = 3'd1, A_IE = 3'd2,
                           A_REN = 3'd3, A_FEN = 3'd4, A_PEND = 3'd5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [W-1:0]  i_sw = '0;
    logic [4:0]    i_wb_adr = '0;
    logic [31:0]   i_wb_dat = '0;
    logic          i_wb_we = 1'b0, i_wb_cyc = 1'b0, i_wb_stb = 1'b0;
    logic          o_wb_ack;
    logic [31:0]   o_wb_rdt;
    logic          o_irq;

    int n_cmp = 0;
    int n_mis = 0;
    bit chk_on = 1'b0;

    always #5 clk = ~clk;

    switch_input_ctrl #(.WIDTH(W), .DEBOUNCE(D)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_sw     (i_sw),
        .i_wb_adr (i_wb_adr),
        .i_wb_dat (i_wb_dat),
        .i_wb_we  (i_wb_we),
        .i_wb_cyc (i_wb_cyc),
        .i_wb_stb (i_wb_stb),
        .o_wb_ack (o_wb_ack),
        .o_wb_rdt (o_wb_rdt),
        .o_irq    (o_irq)
    );

    // Reference model: a channel's debounced level flips once the newest D
    // synchronised samples all disagree with it.
    logic [W-1:0] m_s1, m_s2, m_state, m_prev, m_ie, m_ren, m_fen, m_pend;
    logic [W-1:0] m_hist [D-1];
    logic [W-1:0] m_flip, m_set, m_clr;
    logic         m_ack, m_wr;

    always_comb begin
        m_flip = m_s2 ^ m_state;
        for (int k = 0; k < D - 1; k++) m_flip = m_flip & (m_hist[k] ^ m_state);
    end

    assign m_set = (m_state & ~m_prev & m_ren) | (~m_state & m_prev & m_fen);
    assign m_wr  = m_ack & i_wb_cyc & i_wb_stb & i_wb_we;
    assign m_clr = (m_wr && i_wb_adr[4:2] == A_PEND) ? i_wb_dat[W-1:0] : '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_s1 <= '0; m_s2 <= '0; m_state <= '0; m_prev <= '0;
            m_ie <= '0; m_ren <= '0; m_fen <= '0; m_pend <= '0; m_ack <= 1'b0;
            for (int k = 0; k < D - 1; k++) m_hist[k] <= '0;
        end else begin
            m_s1 <= i_sw;
            m_s2 <= m_s1;
            m_hist[0] <= m_s2;
            for (int k = 1; k < D - 1; k++) m_hist[k] <= m_hist[k-1];
            m_state <= m_state ^ m_flip;
            m_prev  <= m_state;
            m_ack   <= i_wb_cyc & i_wb_stb & ~m_ack;
            if (m_wr) begin
                case (i_wb_adr[4:2])
                    A_IE:  m_ie  <= i_wb_dat[W-1:0];
                    A_REN: m_ren <= i_wb_dat[W-1:0];
                    A_FEN: m_fen <= i_wb_dat[W-1:0];
                    default: ;
                endcase
            end
            m_pend <= (m_pend & ~m_clr) | m_set;
        end
    end

    function automatic logic [31:0] m_read(input logic [2:0] a);
        logic [W-1:0] v;
        case (a)
            A_STATE: v = m_state;
            A_RAW:   v = m_s2;
            A_IE:    v = m_ie;
            A_REN:   v = m_ren;
            A_FEN:   v = m_fen;
            A_PEND:  v = m_pend;
            default: v = '0;
        endcase
        return 32'(v);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            chk("ack_vs_model", 32'(o_wb_ack), 32'(m_ack));
            chk("irq_vs_model", 32'(o_irq), 32'(|(m_pend & m_ie)));
            if (!m_ack) chk("rdt_idle", o_wb_rdt, 32'd0);
        end
    end

    // Called at a negedge; holds the request through the ack cycle, returns at the next-but-one negedge.
    task automatic bus(input bit we, input logic [2:0] a, input logic [31:0] d, output logic [31:0] rd);
        i_wb_adr = {a, 2'b00};
        i_wb_dat = d;
        i_wb_we  = we;
        i_wb_cyc = 1'b1;
        i_wb_stb = 1'b1;
        @(negedge clk);
        rd = o_wb_rdt;
        @(negedge clk);
        i_wb_cyc = 1'b0;
        i_wb_stb = 1'b0;
        i_wb_we  = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [2:0] a, input logic [31:0] exp);
        logic [31:0] rd;
        bus(1'b0, a, 32'd0, rd);
        chk(tag, rd, exp);
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        logic [31:0] rd;
        bus(1'b1, a, d, rd);
    endtask

    initial begin
        logic [31:0] exp;
        logic [2:0]  a;
        int          r, b;

        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_on = 1'b1;
        chk("rst_ack", 32'(o_wb_ack), 32'd0);
        chk("rst_rdt", o_wb_rdt, 32'd0);
        chk("rst_irq", 32'(o_irq), 32'd0);
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) rd_chk("rst_reg", 3'(k), 32'd0);

        // Clean step on channel 0: RAW after 2, STATE after 2+D.
        i_sw = 4'b0001;
        @(negedge clk);
        rd_chk("raw_rise_c1", A_RAW, 32'h0);
        rd_chk("raw_rise_c3", A_RAW, 32'h1);
        rd_chk("state_rise_c5", A_STATE, 32'h0);
        rd_chk("state_rise_c7", A_STATE, 32'h1);
        i_sw = 4'b0000;
        repeat (2) @(negedge clk);
        rd_chk("raw_fall_c2", A_RAW, 32'h0);
        rd_chk("state_fall_c4", A_STATE, 32'h1);
        rd_chk("state_fall_c6", A_STATE, 32'h0);

        // Glitch shorter than the debounce window.
        wr(A_REN, 32'h2);
        i_sw[1] = 1'b1;
        repeat (3) @(negedge clk);
        i_sw[1] = 1'b0;
        repeat (10) @(negedge clk);
        rd_chk("glitch_state", A_STATE, 32'h0);
        rd_chk("glitch_pend", A_PEND, 32'h0);

        // Rise interrupt and W1C.
        wr(A_REN, 32'h4);
        wr(A_IE, 32'h4);
        i_sw[2] = 1'b1;
        repeat (10) @(negedge clk);
        rd_chk("rise_pend", A_PEND, 32'h4);
        chk("rise_irq", 32'(o_irq), 32'd1);
        wr(A_PEND, 32'h4);
        chk("w1c_irq", 32'(o_irq), 32'd0);
        rd_chk("w1c_pend", A_PEND, 32'h0);

        // Fall event with interrupt masked; enabling late does not flag history.
        wr(A_IE, 32'h0);
        wr(A_FEN, 32'h8);
        i_sw[3] = 1'b1;
        repeat (10) @(negedge clk);
        wr(A_REN, 32'hC);
        rd_chk("no_retro_pend", A_PEND, 32'h0);
        i_sw[3] = 1'b0;
        repeat (10) @(negedge clk);
        rd_chk("fall_pend", A_PEND, 32'h8);
        chk("fall_irq_masked", 32'(o_irq), 32'd0);
        wr(A_IE, 32'h8);
        chk("fall_irq_enabled", 32'(o_irq), 32'd1);
        wr(A_PEND, 32'h8);
        chk("fall_irq_cleared", 32'(o_irq), 32'd0);

        // W1C lands on the same edge the rise event sets the bit.
        wr(A_REN, 32'h1);
        i_sw[0] = 1'b1;
        repeat (5) @(negedge clk);
        wr(A_PEND, 32'h1);
        rd_chk("set_beats_w1c", A_PEND, 32'h1);
        wr(A_PEND, 32'h1);

        // Reset mid-debounce (count 2) and mid-transfer.
        i_sw[1] = 1'b1;
        repeat (3) @(negedge clk);
        i_wb_adr = {A_STATE, 2'b00};
        i_wb_we  = 1'b0;
        i_wb_cyc = 1'b1;
        i_wb_stb = 1'b1;
        @(negedge clk);
        chk("ack_before_rst", 32'(o_wb_ack), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_ack", 32'(o_wb_ack), 32'd0);
        chk("rst_mid_rdt", o_wb_rdt, 32'd0);
        chk("rst_mid_irq", 32'(o_irq), 32'd0);
        i_wb_cyc = 1'b0;
        i_wb_stb = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        rd_chk("post_rst_state_c0", A_STATE, 32'h0);
        repeat (2) @(negedge clk);
        rd_chk("post_rst_state_c4", A_STATE, 32'h0);
        rd_chk("post_rst_state_c6", A_STATE, 32'h7);
        rd_chk("post_rst_ie", A_IE, 32'h0);
        rd_chk("post_rst_ren", A_REN, 32'h0);
        rd_chk("post_rst_fen", A_FEN, 32'h0);
        rd_chk("post_rst_pend", A_PEND, 32'h0);

        // Random switch activity and bus traffic against the model.
        for (int it = 0; it < 400; it++) begin
            r = $urandom_range(0, 9);
            if (r < 4) begin
                b = $urandom_range(0, W - 1);
                i_sw[b] = ~i_sw[b];
                @(negedge clk);
            end else if (r < 6) begin
                a   = 3'($urandom_range(0, 7));
                exp = m_read(a);
                rd_chk("rnd_read", a, exp);
            end else if (r < 8) begin
                a = 3'($urandom_range(0, 7));
                wr(a, $urandom);
            end else begin
                repeat ($urandom_range(1, 8)) @(negedge clk);
            end
        end
        repeat (12) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            exp = m_read(3'(k));
            rd_chk("final_read", 3'(k), exp);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
